load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of the byte address on the request side and of the memory address bus.
REQ-002 Parameter DATA_WIDTH, default 32: width of request write data, response read data and the memory data buses; SHALL equal 32.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  unit can accept a request this cycle.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_size_i  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-009 req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_addr_i  input  ADDRESS_WIDTH  byte address.
REQ-011 req_wdata_i  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-012 resp_valid_o  output  1  one-cycle completion pulse.
REQ-013 resp_rdata_o  output  DATA_WIDTH  extended load result; 0 for stores.
REQ-014 resp_misaligned_o  output  1  request was rejected as misaligned; qualified by resp_valid_o.
REQ-015 mem_a_o  output  ADDRESS_WIDTH  word index to data memory = {2'b00, addr[ADDRESS_WIDTH-1:2]}.
REQ-016 mem_wd_o  output  DATA_WIDTH  write word to data memory.
REQ-017 mem_wen_o  output  1  data memory write enable.
REQ-018 mem_rd_i  input  DATA_WIDTH  data memory read word; combinational with respect to mem_a_o.

Function
REQ-019 The state machine SHALL have the states IDLE, READ, WRITE and RESP.
REQ-020 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0. A request is accepted when req_valid_i and req_ready_o are both 1, and all req_* fields SHALL be registered on acceptance.
REQ-021 Transitions from IDLE on acceptance:
- misaligned request (REQ-030) -> RESP
- load -> READ
- word store -> WRITE
- byte or halfword store -> READ (read-modify-write)
REQ-022 READ SHALL drive mem_a_o from the latched address with mem_wen_o=0 and register mem_rd_i. It then goes to RESP for a load, or to WRITE for a store.
REQ-023 WRITE SHALL assert mem_wen_o for exactly that one cycle, with mem_a_o and mem_wd_o stable, then go to RESP.
REQ-024 mem_wen_o SHALL be 0 in every state other than WRITE.
REQ-025 RESP SHALL assert resp_valid_o for one cycle and return to IDLE. With acceptance in cycle T:
- misaligned: RESP at T+1
- load or word store: RESP at T+2
- sub-word store: RESP at T+3
REQ-026 Byte lanes are little-endian, selected by addr[1:0]. A byte load SHALL extract byte addr[1:0]; a halfword load SHALL extract bits [16*addr[1]+15 : 16*addr[1]].
REQ-027 Sub-word store merge: only the addressed byte or halfword lanes of the registered read word are replaced by req_wdata_i; all other lanes SHALL be preserved bit-exact.
REQ-028 resp_rdata_o SHALL hold its value from the RESP cycle until the next RESP, and SHALL be 0 for store responses.
REQ-029 mem_a_o and mem_wd_o SHALL be 0 in IDLE.
REQ-030 A request is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=00.
REQ-031 A request presented while req_ready_o=0 SHALL be ignored; no internal queueing.

Reset
REQ-032 While rst_i=1, regardless of clk_i:
- state = IDLE
- req_ready_o = 0
- resp_valid_o = 0, resp_rdata_o = 0, resp_misaligned_o = 0
- mem_wen_o = 0, mem_a_o = 0, mem_wd_o = 0
REQ-033 Reset asserted mid-transaction SHALL abort the transaction with no resp_valid_o pulse. A reset that arrives during WRITE SHALL drop mem_wen_o immediately.
REQ-034 On the first clk_i edge after rst_i deasserts, req_ready_o SHALL be 1.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN defined: misaligned requests follow REQ-021/REQ-025 with resp_misaligned_o=1, no memory access and resp_rdata_o=0.
REQ-036 MISALIGN_TRAP_EN undefined: no alignment check is made. The effective lane offset is forced aligned (halfword uses addr[1], word uses lane 0), and resp_misaligned_o is tied to 0.

Verification
REQ-037 Memory word 0x10 = 0x8899AABB; load byte, signed, addr 0x41 -> resp at T+2, rdata 0xFFFFFFAA.
REQ-038 Same word; load halfword, unsigned, addr 0x42 -> rdata 0x00008899.
REQ-039 Word 0x10 = 0x8899AABB; store byte 0x5C to addr 0x43 -> one mem_wen_o pulse at T+2, word becomes 0x5C99AABB, resp at T+3.
REQ-040 Store word 0xDEADBEEF to addr 0x44 -> mem_a_o=0x11, mem_wen_o high for exactly one cycle at T+1, resp at T+2.
REQ-041 MISALIGN_TRAP_EN defined; load word at addr 0x46 -> resp at T+1 with resp_misaligned_o=1, mem_wen_o never 1, rdata 0.
REQ-042 Assert rst_i during WRITE of a sub-word store -> mem_wen_o falls immediately, no resp_valid_o, req_ready_o=1 one cycle after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/halfword/word access with read-modify-write sub-word stores.
// Optional MISALIGN_TRAP_EN rejects misaligned requests; without it, lane offsets are forced aligned.
module load_store_unit #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [1:0]               req_size_i,
   input  logic                     req_unsigned_i,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_wdata_i,
   output logic                     resp_valid_o,
   output logic [DATA_WIDTH-1:0]    resp_rdata_o,
   output logic                     resp_misaligned_o,
   output logic [ADDRESS_WIDTH-1:0] mem_a_o,
   output logic [DATA_WIDTH-1:0]    mem_wd_o,
   output logic                     mem_wen_o,
   input  logic [DATA_WIDTH-1:0]    mem_rd_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                  state_q;
   logic                    we_q;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [1:0]              off_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [1:0]              req_off;
   logic                    req_mis;

   function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [1:0] size,
                                                      input logic uns,
                                                      input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (size)
         2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   // Replace only the addressed lanes of the word read back from memory.
   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] w,
                                                   input logic [DATA_WIDTH-1:0] wd,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off);
      logic [DATA_WIDTH-1:0] m;
      logic [DATA_WIDTH-1:0] d;
      case (size)
         2'b00: begin
            m = 32'h0000_00FF << {off, 3'b000};
            d = {24'b0, wd[7:0]} << {off, 3'b000};
         end
         2'b01: begin
            m = 32'h0000_FFFF << {off, 3'b000};
            d = {16'b0, wd[15:0]} << {off, 3'b000};
         end
         default: begin
            m = '1;
            d = wd;
         end
      endcase
      merge = (w & ~m) | (d & m);
   endfunction

   always_comb begin
      case (req_size_i)
         2'b00:   req_off = req_addr_i[1:0];
         2'b01:   req_off = {req_addr_i[1], 1'b0};
         default: req_off = 2'b00;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign req_mis = (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i[1] && req_addr_i[1:0] != 2'b00);
`else
   assign req_mis = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         req_ready_o       <= 1'b0;
         resp_valid_o      <= 1'b0;
         resp_rdata_o      <= '0;
         resp_misaligned_o <= 1'b0;
         mem_a_o           <= '0;
         mem_wd_o          <= '0;
         mem_wen_o         <= 1'b0;
         we_q              <= 1'b0;
         size_q            <= 2'b00;
         uns_q             <= 1'b0;
         off_q             <= 2'b00;
         wdata_q           <= '0;
      end else begin
         resp_valid_o <= 1'b0;
         mem_wen_o    <= 1'b0;
         req_ready_o  <= 1'b0;
         case (state_q)
            IDLE: begin
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  we_q        <= req_we_i;
                  size_q      <= req_size_i;
                  uns_q       <= req_unsigned_i;
                  off_q       <= req_off;
                  wdata_q     <= req_wdata_i;
                  if (req_mis) begin
                     state_q           <= RESP;
                     resp_valid_o      <= 1'b1;
                     resp_misaligned_o <= 1'b1;
                     resp_rdata_o      <= '0;
                  end else begin
                     mem_a_o <= {2'b00, req_addr_i[ADDRESS_WIDTH-1:2]};
                     if (req_we_i && req_size_i[1]) begin
                        state_q   <= WRITE;
                        mem_wd_o  <= req_wdata_i;
                        mem_wen_o <= 1'b1;
                     end else begin
                        state_q <= READ;
                     end
                  end
               end
            end
            READ: begin
               if (!we_q) begin
                  state_q           <= RESP;
                  resp_valid_o      <= 1'b1;
                  resp_misaligned_o <= 1'b0;
                  resp_rdata_o      <= load_ext(mem_rd_i, size_q, uns_q, off_q);
                  mem_a_o           <= '0;
               end else begin
                  state_q   <= WRITE;
                  mem_wd_o  <= merge(mem_rd_i, wdata_q, size_q, off_q);
                  mem_wen_o <= 1'b1;
               end
            end
            WRITE: begin
               state_q           <= RESP;
               resp_valid_o      <= 1'b1;
               resp_misaligned_o <= 1'b0;
               resp_rdata_o      <= '0;
               mem_a_o           <= '0;
               mem_wd_o          <= '0;
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model plus scoreboard of expected responses.
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_misaligned_o;
   logic [31:0] mem_a_o;
   logic [31:0] mem_wd_o;
   logic        mem_wen_o;
   logic [31:0] mem_rd_i;

   always #5 clk_i = ~clk_i;

   load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
      .resp_misaligned_o(resp_misaligned_o),
      .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_wen_o(mem_wen_o), .mem_rd_i(mem_rd_i)
   );

   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] mem_idx;

   assign mem_idx  = mem_a_o % 32'd256;
   assign mem_rd_i = mem[mem_idx];

   always @(posedge clk_i) if (mem_wen_o) mem[mem_idx] <= mem_wd_o;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
      int          wen_n;
      int          wen_lat;
      logic [31:0] a;
   } exp_t;

   exp_t sb[$];
   int   acc_cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference behaviour, written per byte lane; also advances the shadow memory for stores.
   task automatic build_exp(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
      logic [7:0]  by [4];
      logic [15:0] h;
      int          idx;
      int          off;
      logic        mis;
      e   = '{rdata: '0, mis: 1'b0, lat: 0, wen_n: 0, wen_lat: 0, a: '0};
      idx = int'((addr >> 2) % 32'd256);
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`endif
      if (mis) begin
         e.mis = 1'b1;
         e.lat = 1;
         return;
      end
      for (int i = 0; i < 4; i++) by[i] = ref_mem[idx][8*i +: 8];
      case (size)
         2'b00:   off = int'(addr[1:0]);
         2'b01:   off = addr[1] ? 2 : 0;
         default: off = 0;
      endcase
      e.a = addr >> 2;
      if (!we) begin
         e.lat = 2;
         case (size)
            2'b00: e.rdata = uns ? {24'h0, by[off]} : {{24{by[off][7]}}, by[off]};
            2'b01: begin
               h = {by[off+1], by[off]};
               e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: e.rdata = ref_mem[idx];
         endcase
      end else begin
         e.wen_n = 1;
         if (size[1]) begin
            ref_mem[idx] = wd;
            e.lat = 2;
            e.wen_lat = 1;
         end else begin
            by[off] = wd[7:0];
            if (size == 2'b01) by[off+1] = wd[15:8];
            ref_mem[idx] = {by[3], by[2], by[1], by[0]};
            e.lat = 3;
            e.wen_lat = 2;
         end
      end
   endtask

   int          wen_seen = 0;
   int          wen_lat = 0;
   logic [31:0] wen_a = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            wen_seen = 0;
         end else begin
            if (mem_wen_o) begin
               wen_seen++;
               wen_lat = cyc - acc_cyc;
               wen_a   = mem_a_o;
            end
            if (resp_valid_o) begin
               if (sb.size() == 0) begin
                  check("unexpected_resp", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("resp_rdata", resp_rdata_o, e.rdata);
                  check("resp_mis", {31'b0, resp_misaligned_o}, {31'b0, e.mis});
                  check("resp_lat", cyc - acc_cyc, e.lat);
                  check("wen_count", wen_seen, e.wen_n);
                  if (e.wen_n > 0) begin
                     check("wen_lat", wen_lat, e.wen_lat);
                     check("wen_addr", wen_a, e.a);
                  end
               end
               wen_seen = 0;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      bit   got;
      @(negedge clk_i);
      check("idle_ready", {31'b0, req_ready_o}, 32'd1);
      check("idle_mem_a", mem_a_o, 32'd0);
      check("idle_mem_wd", mem_wd_o, 32'd0);
      build_exp(we, size, uns, addr, wd, e);
      sb.push_back(e);
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      req_valid_i    = 1'b1;
      acc_cyc        = cyc;
      @(posedge clk_i);
      #1;
      // Keep valid high with junk fields while busy: these must be ignored.
      req_we_i    = ~we;
      req_size_i  = 2'($urandom);
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk_i);
         if (resp_valid_o) got = 1'b1;
      end
      req_valid_i = 1'b0;
      if (!got) check("resp_timeout", 32'd0, 32'd1);
      if (we) check("mem_word", mem[(addr >> 2) % 32'd256], ref_mem[(addr >> 2) % 32'd256]);
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] saved;
      bit          seen;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem[i] <= v;
         ref_mem[i] = v;
      end
      mem[16] <= 32'h8899AABB;
      ref_mem[16] = 32'h8899AABB;

      #2 rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_ready", {31'b0, req_ready_o}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
      check("rst_rdata", resp_rdata_o, 32'd0);
      check("rst_mis", {31'b0, resp_misaligned_o}, 32'd0);
      check("rst_wen", {31'b0, mem_wen_o}, 32'd0);
      check("rst_mem_a", mem_a_o, 32'd0);
      check("rst_mem_wd", mem_wd_o, 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1 check("ready_first_edge", {31'b0, req_ready_o}, 32'd1);

      do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
      check("byte_load_signed", resp_rdata_o, 32'hFFFFFFAA);
      do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
      check("half_load_unsigned", resp_rdata_o, 32'h00008899);
      repeat (3) @(negedge clk_i);
      check("rdata_hold", resp_rdata_o, 32'h00008899);
      do_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h1234565C);
      check("byte_store_merge", mem[16], 32'h5C99AABB);
      check("store_rdata_zero", resp_rdata_o, 32'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF);
      check("word_store", mem[17], 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h46, 32'h0);
      do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
      do_req(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000A5C3);
      do_req(1'b0, 2'b11, 1'b1, 32'h40, 32'h0);

      for (int k = 0; k < 40; k++)
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                {22'h0, 8'($urandom_range(0, 63)), 2'($urandom)}, $urandom);

      // Abort a sub-word store by reset while it is writing.
      saved = mem[18];
      @(negedge clk_i);
      req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      req_addr_i = 32'h49; req_wdata_i = 32'h000000E7; req_valid_i = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 6 && !seen; n++) begin
         @(negedge clk_i);
         if (mem_wen_o) seen = 1'b1;
      end
      check("abort_wen_reached", {31'b0, seen}, 32'd1);
      req_valid_i = 1'b0;
      #1 rst_i = 1'b1;
      #1;
      check("abort_wen_drop", {31'b0, mem_wen_o}, 32'd0);
      check("abort_ready", {31'b0, req_ready_o}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk_i);
         check("abort_no_resp", {31'b0, resp_valid_o}, 32'd0);
      end
      rst_i = 1'b0;
      @(posedge clk_i);
      #1 check("abort_ready_after", {31'b0, req_ready_o}, 32'd1);
      check("abort_mem_untouched", mem[18], saved);
      check("abort_no_resp_after", {31'b0, resp_valid_o}, 32'd0);

      do_req(1'b0, 2'b10, 1'b0, 32'h48, 32'h0);
      repeat (2) @(negedge clk_i);
      check("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

endmodule
